mul_wb_sched: RTL and testbench

//  Controls the register-file write port for multi-cycle multiply instructions.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/mul_wb_sched.sv | 110 +++++++++++
 tb/tb_mul_wb_sched.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths and the multiply-writeback scheduler state type
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int RAW  = 5;
    typedef enum logic [1:0] {IDLE, BUSY, WRITE} mulwb_state_e;
endpackage

// File: rtl/mul_wb_sched.sv
// mul_wb_sched: launches an iterative multiply, stalls the pipeline until its
// result arrives, and merges that result onto the single register-file write
// port alongside normal writeback (normal writeback always has priority).
// Optional: define MULWB_PERF_EN to add the saturating perf_stall_cyc counter.
module mul_wb_sched #(
    parameter int XLEN    = cpu_pkg::XLEN,
    parameter int RAW     = cpu_pkg::RAW,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_req,
    input  logic [RAW-1:0]  mul_rd,
    output logic            mul_start,
    input  logic            mul_ready,
    input  logic [XLEN-1:0] mul_out,
    input  logic            wb_valid,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            rf_we,
    output logic [RAW-1:0]  rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            stall,
    output logic            mul_err
`ifdef MULWB_PERF_EN
    ,
    output logic [31:0]     perf_stall_cyc
`endif
);
    import cpu_pkg::*;

    localparam int CW = $clog2(TIMEOUT);

    mulwb_state_e    r_state;
    mulwb_state_e    w_next;
    logic [RAW-1:0]  r_rd;
    logic [XLEN-1:0] r_res;
    logic [CW-1:0]   r_cnt;
    logic            r_mul_start;
    logic            r_mul_err;
    logic            w_launch;
    logic            w_timeout;
    logic            w_mul_wb;

    // Next state, launch/timeout strobes and the write-port merge
    always_comb begin
        w_next    = r_state;
        w_launch  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                w_launch = mul_req;
                w_next   = mul_req ? BUSY : IDLE;
            end
            BUSY: begin
                w_timeout = !mul_ready && (r_cnt == CW'(TIMEOUT - 1));
                w_next    = mul_ready ? WRITE : (w_timeout ? IDLE : BUSY);
            end
            WRITE:   w_next = wb_valid ? WRITE : IDLE;
            default: w_next = IDLE;
        endcase
        w_mul_wb = (r_state == WRITE) && !wb_valid;
        rf_we    = w_mul_wb ? (r_rd != '0) : (wb_valid && (wb_rd != '0));
        rf_waddr = w_mul_wb ? r_rd : wb_rd;
        rf_wdata = w_mul_wb ? r_res : wb_data;
        stall    = (r_state == BUSY) || ((r_state == IDLE) ? mul_req : wb_valid);
    end

    // State register plus captured destination, result, timeout count and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rd        <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_mul_start <= 1'b0;
            r_mul_err   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_mul_start <= w_launch;
            if (w_launch) begin
                r_rd  <= mul_rd;
                r_cnt <= '0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == BUSY && mul_ready)
                r_res <= mul_out;
            if (w_timeout)
                r_mul_err <= 1'b1;
        end
    end

    assign mul_start = r_mul_start;
    assign mul_err   = r_mul_err;

`ifdef MULWB_PERF_EN
    logic [31:0] r_perf;

    // Saturating count of clock edges seen with stall high
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_perf <= '0;
        else if (stall && (r_perf != 32'hFFFF_FFFF))
            r_perf <= r_perf + 32'd1;
    end

    assign perf_stall_cyc = r_perf;
`endif
endmodule

// File: tb/tb_mul_wb_sched.sv
// tb_mul_wb_sched: randomized self-checking bench for mul_wb_sched
module tb_mul_wb_sched;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mul_req = 1'b0;
    logic [4:0]  mul_rd = '0;
    logic        mul_start;
    logic        mul_ready = 1'b0;
    logic [31:0] mul_out = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall;
    logic        mul_err;
`ifdef MULWB_PERF_EN
    logic [31:0] perf_stall_cyc;
`endif

    int checks = 0;
    int failures = 0;
    logic exp_err = 1'b0;
    int exp_perf = 0;

    mul_wb_sched #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mul_req(mul_req), .mul_rd(mul_rd), .mul_start(mul_start),
        .mul_ready(mul_ready), .mul_out(mul_out),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall(stall), .mul_err(mul_err)
`ifdef MULWB_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc)
`endif
    );

    always #5 clk = ~clk;

    // One multiply transaction: launch, `lat` busy cycles (0 = never ready, times out),
    // `nconf` cycles of competing writeback in WRITE, the multiply write, one idle cycle.
    task automatic run_mul(input string name, input logic [4:0] rd, input int lat,
                           input logic [31:0] res, input int nconf);
        int busy = (lat == 0) ? TO : lat;
        int fin = busy + nconf + 1;
        int n = (lat == 0) ? busy + 2 : fin + 2;
        logic is_fin, e_stall, e_start, e_we;
        logic [4:0] e_addr;
        logic [31:0] e_data;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            mul_req   = (i == 0) ? 1'b1 : (i == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            mul_rd    = (i == 0) ? rd : 5'($urandom);
            mul_ready = (i >= 1 && i <= busy) ? (i == lat) : 1'($urandom_range(0, 1));
            mul_out   = (i == lat) ? res : $urandom;
            wb_valid  = (lat > 0 && i > busy && i < fin) ? 1'b1 :
                        (lat > 0 && i == fin) ? 1'b0 : 1'($urandom_range(0, 1));
            wb_rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            wb_data   = $urandom;
            is_fin  = (lat > 0) && (i == fin);
            e_stall = (i <= busy) || (lat > 0 && i < fin);
            e_start = (i == 1);
            e_we    = is_fin ? (rd != 0) : (wb_valid && wb_rd != 0);
            e_addr  = is_fin ? rd : wb_rd;
            e_data  = is_fin ? res : wb_data;
            if (lat == 0 && i > busy) exp_err = 1'b1;
            @(negedge clk);
            checks += 6;
            if (stall !== e_stall) begin failures++; $display("FAIL %s stall cyc%0d: got %b expected %b", name, i, stall, e_stall); end
            if (mul_start !== e_start) begin failures++; $display("FAIL %s mul_start cyc%0d: got %b expected %b", name, i, mul_start, e_start); end
            if (rf_we !== e_we) begin failures++; $display("FAIL %s rf_we cyc%0d: got %b expected %b", name, i, rf_we, e_we); end
            if (rf_waddr !== e_addr) begin failures++; $display("FAIL %s rf_waddr cyc%0d: got %0d expected %0d", name, i, rf_waddr, e_addr); end
            if (rf_wdata !== e_data) begin failures++; $display("FAIL %s rf_wdata cyc%0d: got %h expected %h", name, i, rf_wdata, e_data); end
            if (mul_err !== exp_err) begin failures++; $display("FAIL %s mul_err cyc%0d: got %b expected %b", name, i, mul_err, exp_err); end
            if (e_stall) exp_perf++;
        end
`ifdef MULWB_PERF_EN
        checks++;
        if (perf_stall_cyc !== 32'(exp_perf)) begin failures++; $display("FAIL %s perf_stall_cyc: got %0d expected %0d", name, perf_stall_cyc, exp_perf); end
`endif
    endtask

    task automatic test_reset();
        #2;
        checks += 4;
        if (mul_start !== 1'b0) begin failures++; $display("FAIL reset mul_start: got %b expected 0", mul_start); end
        if (mul_err !== 1'b0) begin failures++; $display("FAIL reset mul_err: got %b expected 0", mul_err); end
        if (stall !== 1'b0) begin failures++; $display("FAIL reset stall: got %b expected 0", stall); end
        if (rf_we !== 1'b0) begin failures++; $display("FAIL reset rf_we: got %b expected 0", rf_we); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        exp_perf = 0;
    endtask

    task automatic test_basic();
        run_mul("basic", 5'd5, 5, 32'h0000_0F00, 0);
`ifdef MULWB_PERF_EN
        checks++;
        if (perf_stall_cyc !== 32'd6) begin failures++; $display("FAIL basic perf6: got %0d expected 6", perf_stall_cyc); end
`endif
    endtask

    task automatic test_wb_conflict();
        run_mul("conflict", 5'd5, $urandom_range(1, 8), $urandom, 2);
    endtask

    task automatic test_x0();
        run_mul("x0", 5'd0, $urandom_range(1, 8), $urandom, $urandom_range(0, 2));
    endtask

    task automatic test_timeout_race();
        run_mul("race", 5'($urandom_range(1, 31)), TO, $urandom, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++)
            run_mul("random", 5'($urandom), $urandom_range(1, 12), $urandom, $urandom_range(0, 3));
    endtask

    task automatic test_timeout();
        run_mul("timeout", 5'd9, 0, 32'h0, 0);
        run_mul("after_timeout", 5'd7, 3, $urandom, 1);
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        mul_req = 1'b1; mul_rd = 5'd12; mul_ready = 1'b0; wb_valid = 1'b0;
        @(posedge clk); #1;
        mul_req = 1'b0;
        checks++;
        if (mul_start !== 1'b1) begin failures++; $display("FAIL midrst start_before: got %b expected 1", mul_start); end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (mul_start !== 1'b0) begin failures++; $display("FAIL midrst mul_start: got %b expected 0", mul_start); end
        if (stall !== 1'b0) begin failures++; $display("FAIL midrst stall: got %b expected 0", stall); end
        if (mul_err !== 1'b0) begin failures++; $display("FAIL midrst mul_err: got %b expected 0", mul_err); end
        exp_err = 1'b0;
        exp_perf = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mul_ready = (i == 0);
            mul_out = $urandom;
            @(negedge clk);
            checks += 3;
            if (rf_we !== 1'b0) begin failures++; $display("FAIL midrst rf_we cyc%0d: got %b expected 0", i, rf_we); end
            if (stall !== 1'b0) begin failures++; $display("FAIL midrst stall_after cyc%0d: got %b expected 0", i, stall); end
            if (mul_err !== 1'b0) begin failures++; $display("FAIL midrst err_after cyc%0d: got %b expected 0", i, mul_err); end
        end
        mul_ready = 1'b0;
        run_mul("after_reset", 5'd4, 2, $urandom, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wb_conflict();
        test_x0();
        test_timeout_race();
        test_random();
        test_timeout();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
